sinh_cosh_h: RTL



---
 rtl/hyp_cordic_pkg.sv | 28 ++
 rtl/hyp_atanh_rom.sv | 12 +
 rtl/sinh_cosh_h.sv | 127 ++++++++++++
 3 files changed

// File: rtl/hyp_cordic_pkg.sv
// Shared constants for the hyperbolic CORDIC blocks (sinh/cosh rotation and arctanh vectoring).
// Q2.14 angle constants, start gain, range limit, FSM encodings and result-bus func codes.
package hyp_cordic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [15:0] K_INV = 16'h4D48;
  localparam logic [15:0] ZMAX  = 16'h4790;

  localparam logic [3:0] FUNC_SC_DEF  = 4'd5;
  localparam logic [3:0] FUNC_EXP_DEF = 4'd6;

  localparam logic [3:0] I_FIRST = 4'd1;
  localparam logic [3:0] I_LAST  = 4'd15;
  localparam logic [3:0] I_REP_A = 4'd4;
  localparam logic [3:0] I_REP_B = 4'd13;

  // Entry 0 is unused by the iteration sequence and reads as zero.
  localparam logic [15:0] ATANH [16] = '{
    16'h0000, 16'h2327, 16'h1058, 16'h080A, 16'h0401, 16'h0200, 16'h0100, 16'h0080,
    16'h0040, 16'h0020, 16'h0010, 16'h0008, 16'h0004, 16'h0002, 16'h0001, 16'h0000
  };

endpackage

// File: rtl/hyp_atanh_rom.sv
// atanh(2^-i) lookup in Q2.14; purely combinational, zero latency.
// No flow control: output follows i in the same cycle.
module hyp_atanh_rom
  import hyp_cordic_pkg::*;
(
  input  logic [3:0]  i,
  output logic [15:0] atanh
);

  assign atanh = ATANH[i];

endmodule

// File: rtl/sinh_cosh_h.sv
// Hyperbolic CORDIC rotation: z -> cosh, sinh, e^z; 17 cycles from load to done, one iteration per clock.
// No backpressure: st is only accepted in IDLE/DONE, results hold in DONE until the next start.
module sinh_cosh_h
  import hyp_cordic_pkg::*;
#(
  parameter logic [3:0] FUNC_SC  = FUNC_SC_DEF,
  parameter logic [3:0] FUNC_EXP = FUNC_EXP_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        st,
  input  logic [15:0] z_in,
  input  logic [3:0]  func,
  output logic [15:0] cosh,
  output logic [15:0] sinh,
  output logic [17:0] expz,
  output logic        done,
  output logic        range_err,
  output logic [31:0] result
);

  state_t             state, state_nxt;
  logic signed [17:0] x, y;
  logic signed [15:0] z;
  logic [3:0]         i;
  logic               rep;
  logic               range_err_q;

  logic               load, step, hold;
  logic [15:0]        atanh;
  logic signed [17:0] x_sh, y_sh, x_rot, y_rot;
  logic signed [15:0] z_rot;
  logic signed [16:0] z_ext, z_abs;
  logic               range_hit;
  logic               out_ok;
  logic [17:0]        sum;

  hyp_atanh_rom u_rom (
    .i     (i),
    .atanh (atanh)
  );

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (st) begin
          load      = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        step = 1'b1;
        if (i == I_LAST) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (st) begin
          load      = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Micro-rotation: direction follows the sign of the residual angle.
  assign x_sh  = x >>> i;
  assign y_sh  = y >>> i;
  assign x_rot = z[15] ? (x - y_sh) : (x + y_sh);
  assign y_rot = z[15] ? (y - x_sh) : (y + x_sh);
  assign z_rot = z[15] ? (z + $signed(atanh)) : (z - $signed(atanh));

  // Iterations 4 and 13 run twice; rep marks that the first pass is done.
  assign hold = ((i == I_REP_A) || (i == I_REP_B)) && !rep;

  assign z_ext     = {z_in[15], z_in};
  assign z_abs     = z_ext[16] ? -z_ext : z_ext;
  assign range_hit = $unsigned(z_abs) > {1'b0, ZMAX};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      x           <= '0;
      y           <= '0;
      z           <= '0;
      i           <= I_FIRST;
      rep         <= 1'b0;
      range_err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load) begin
        x           <= {2'b00, K_INV};
        y           <= '0;
        z           <= z_in;
        i           <= I_FIRST;
        rep         <= 1'b0;
        range_err_q <= range_hit;
      end else if (step) begin
        x <= x_rot;
        y <= y_rot;
        z <= z_rot;
        if (hold) begin
          rep <= 1'b1;
        end else begin
          rep <= 1'b0;
          i   <= i + 4'd1;
        end
      end
    end
  end

  assign done      = (state == ST_DONE);
  assign range_err = done && range_err_q;
  assign out_ok    = done && !range_err_q;
  assign sum       = x + y;

  assign cosh = out_ok ? x[15:0] : 16'h0000;
  assign sinh = out_ok ? y[15:0] : 16'h0000;
  assign expz = out_ok ? sum     : 18'h00000;

  assign result = (func == FUNC_SC)  ? {cosh, sinh} :
                  (func == FUNC_EXP) ? {14'b0, expz} :
                                       32'bz;

endmodule
